// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive FIFO controller.
package uart_rx_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned WORD_W = 11;

    // Error flag bit positions inside a received word
    localparam int unsigned ERR_PE = 8;
    localparam int unsigned ERR_FE = 9;
    localparam int unsigned ERR_BI = 10;

    typedef struct packed {
        logic              bi;
        logic              fe;
        logic              pe;
        logic [DATA_W-1:0] data;
    } rx_word_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } rx_ctrl_state_e;

    // FCR trigger select to FIFO fill level
    function automatic logic [3:0] trig_lut(input logic [1:0] sel);
        case (sel)
            2'b00:   trig_lut = 4'd1;
            2'b01:   trig_lut = 4'd4;
            2'b10:   trig_lut = 4'd8;
            default: trig_lut = 4'd14;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_timeout.sv
// Character timeout: counts bit ticks while data waits unread in the FIFO.
// Instantiated only when UART_RX_TIMEOUT_EN is defined.
module uart_rx_timeout #(
    parameter int unsigned TO_TICKS = 40
) (
    input  logic clk,
    input  logic rstn,
    input  logic bit_tick,
    input  logic fifo_empty,
    input  logic push,
    input  logic pop,
    input  logic clr,
    output logic to_flag
);

    localparam int unsigned TW = $clog2(TO_TICKS);

    logic [TW-1:0] cnt;
    logic          at_max;

    assign at_max = (cnt == TW'(TO_TICKS - 1));

    // Tick counter, restarted by any FIFO activity, saturating at its last value
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (push || pop || fifo_empty || clr) begin
            cnt <= '0;
        end else if (bit_tick && !at_max) begin
            cnt <= cnt + TW'(1);
        end
    end

    // Timeout flag, held until the host reads or the FIFO is flushed
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            to_flag <= 1'b0;
        end else if (pop || clr) begin
            to_flag <= 1'b0;
        end else if (bit_tick && at_max && !push && !fifo_empty) begin
            to_flag <= 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// RX FIFO sequencer for the 16550-style UART: admission, overrun, RBR pops,
// LSR receive flags, error-entry count and receive interrupt.
// Optional character timeout enabled by defining UART_RX_TIMEOUT_EN.
module uart_rx_fifo_ctrl
    import uart_rx_pkg::*;
#(
    parameter  int unsigned DEPTH    = 16,
    parameter  int unsigned TO_TICKS = 40,
    localparam int unsigned CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rx_valid,
    input  logic [WORD_W-1:0] rx_word,
    input  logic              bit_tick,
    input  logic              rbr_rd,
    input  logic              lsr_rd,
    input  logic              fcr_rx_rst,
    input  logic [1:0]        fcr_trig,
    input  logic              ier_rda,
    input  logic              ier_rls,
    input  logic [CNT_W-1:0]  fifo_count,
    input  logic              fifo_empty,
    input  logic              fifo_full,
    input  logic [WORD_W-1:0] fifo_data,
    output logic              fifo_push,
    output logic              fifo_pop,
    output logic [WORD_W-1:0] fifo_wdata,
    output logic [DATA_W-1:0] rbr_data,
    output logic [4:0]        lsr_rx,
    output logic              data_ready,
    output logic              irq_rx
);

    rx_ctrl_state_e   state;
    rx_ctrl_state_e   state_nxt;
    rx_word_t         head;
    rx_word_t         inword;
    logic             flush_entry;
    logic             overrun;
    logic             head_evt;
    logic             apply_head;
    logic             in_err;
    logic             head_err;
    logic             bi;
    logic             fe;
    logic             pe;
    logic             oe;
    logic             to_flag;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] trig;

    assign head       = rx_word_t'(fifo_data);
    assign inword     = rx_word_t'(rx_word);
    assign fifo_wdata = rx_word;
    assign in_err     = |{inword.bi, inword.fe, inword.pe};
    assign head_err   = |{head.bi, head.fe, head.pe};
    assign apply_head = head_evt && (state == IDLE);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: flush request starts a drain that ends once the FIFO is empty
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fcr_rx_rst) state_nxt = FLUSH;
            FLUSH:   if (fifo_empty) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FIFO strobes; pop is gated by non-empty so count 0 never sees push+pop
    always_comb begin
        fifo_push   = 1'b0;
        fifo_pop    = 1'b0;
        overrun     = 1'b0;
        flush_entry = 1'b0;
        case (state)
            IDLE: begin
                fifo_pop    = rbr_rd && !fifo_empty;
                fifo_push   = rx_valid && (!fifo_full || fifo_pop);
                overrun     = rx_valid && fifo_full && !fifo_pop;
                flush_entry = fcr_rx_rst;
            end
            FLUSH: begin
                fifo_pop = !fifo_empty;
            end
            default: ;
        endcase
    end

    // Marks a cycle where a new word has just reached the FIFO head
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_evt <= 1'b0;
        end else begin
            head_evt <= (state == IDLE) &&
                        ((fifo_push && fifo_empty) ||
                         (fifo_pop && ((fifo_count > CNT_W'(1)) || fifo_push)));
        end
    end

    // Sticky line-status flags; a same-cycle set beats an LSR read clear
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bi <= 1'b0;
            fe <= 1'b0;
            pe <= 1'b0;
            oe <= 1'b0;
        end else begin
            oe <= overrun || (oe && !lsr_rd);
            if (flush_entry) begin
                bi <= 1'b0;
                fe <= 1'b0;
                pe <= 1'b0;
            end else begin
                bi <= (apply_head && head.bi) || (bi && !lsr_rd);
                fe <= (apply_head && head.fe) || (fe && !lsr_rd);
                pe <= (apply_head && head.pe) || (pe && !lsr_rd);
            end
        end
    end

    // Number of FIFO entries carrying any error flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_cnt <= '0;
        end else if (flush_entry || (state == FLUSH)) begin
            err_cnt <= '0;
        end else begin
            case ({fifo_push && in_err, fifo_pop && head_err})
                2'b10:   err_cnt <= err_cnt + CNT_W'(1);
                2'b01:   err_cnt <= err_cnt - CNT_W'(1);
                default: err_cnt <= err_cnt;
            endcase
        end
    end

`ifdef UART_RX_TIMEOUT_EN
    uart_rx_timeout #(
        .TO_TICKS (TO_TICKS)
    ) u_timeout (
        .clk        (clk),
        .rstn       (rstn),
        .bit_tick   (bit_tick),
        .fifo_empty (fifo_empty),
        .push       (fifo_push),
        .pop        (fifo_pop),
        .clr        (flush_entry || (state == FLUSH)),
        .to_flag    (to_flag)
    );
`else
    logic unused_tick;
    assign unused_tick = bit_tick & (TO_TICKS != 0);
    assign to_flag     = 1'b0;
`endif

    assign trig       = CNT_W'(trig_lut(fcr_trig));
    assign rbr_data   = ((state == IDLE) && !fifo_empty) ? head.data : '0;
    assign lsr_rx     = {(err_cnt != '0), bi, fe, pe, oe};
    assign data_ready = !fifo_empty;
    assign irq_rx     = (ier_rda && ((fifo_count >= trig) || to_flag)) ||
                        (ier_rls && (bi || fe || pe || oe));

endmodule
